// File: rtl/modbus_frame_tx.sv
// Modbus RTU frame sequencer. Takes payload bytes from a valid/ready stream,
// feeds each one to the external CRC16 engine and to the UART transmitter,
// then appends CRC low and CRC high bytes and pulses frame_done.
//
// Handshake: a payload byte is transferred on a rising clock edge where
// s_valid and s_ready are both 1. s_ready does not depend on s_valid. While
// s_ready is 0 the upstream must hold s_valid, s_data and s_last stable. The
// UART side uses tx_start as a one-cycle command; tx_busy must rise no later
// than the cycle after tx_start.
module modbus_frame_tx #(
    parameter int CRC_CYCLES = 17,
    parameter int LEN_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             crc_init,
    output logic             crc_load,
    output logic [7:0]       crc_byte,
    input  logic [7:0]       crc_l,
    input  logic [7:0]       crc_h,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    input  logic             tx_busy,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_len
);

    localparam int CW = $clog2(CRC_CYCLES);
    localparam logic [CW-1:0]    WAIT_INIT = CW'(CRC_CYCLES - 1);
    localparam logic [CW-1:0]    WAIT_ONE  = CW'(1);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX   = {LEN_W{1'b1}};

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        GET_FIRST = 4'd1,
        GET       = 4'd2,
        LOAD      = 4'd3,
        SEND_D    = 4'd4,
        GUARD_D   = 4'd5,
        HOLD      = 4'd6,
        CRC_LO    = 4'd7,
        GUARD_L   = 4'd8,
        CRC_HI    = 4'd9
    } state_t;

    state_t          state;
    logic [7:0]      byte_q;
    logic            last_q;
    logic [CW-1:0]   wait_cnt;

    // The CRC engine is held at its initial value whenever no frame is in flight.
    assign crc_init = (state == IDLE) || (state == GET_FIRST);

    // Frame sequencer: payload intake, CRC load and settle wait, UART starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            s_ready    <= 1'b0;
            crc_load   <= 1'b0;
            crc_byte   <= 8'h00;
            tx_data    <= 8'h00;
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            byte_q     <= 8'h00;
            last_q     <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            crc_load   <= 1'b0;
            tx_start   <= 1'b0;
            frame_done <= 1'b0;

            // CRC settle timer: armed in LOAD, then counts down to zero and stops.
            if (state == LOAD) begin
                wait_cnt <= WAIT_INIT;
            end else if (wait_cnt != '0) begin
                wait_cnt <= wait_cnt - WAIT_ONE;
            end

            case (state)
                IDLE: begin
                    frame_len <= '0;
                    s_ready   <= 1'b1;
                    state     <= GET_FIRST;
                end
                GET_FIRST, GET: begin
                    if (s_valid && s_ready) begin
                        byte_q   <= s_data;
                        last_q   <= s_last;
                        crc_byte <= s_data;
                        crc_load <= 1'b1;
                        s_ready  <= 1'b0;
                        if (state == GET_FIRST) begin
                            frame_len <= LEN_ONE;
                        end else if (frame_len != LEN_MAX) begin
                            frame_len <= frame_len + LEN_ONE;
                        end
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state <= SEND_D;
                end
                SEND_D: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= byte_q;
                        state    <= GUARD_D;
                    end
                end
                GUARD_D: begin
                    // tx_busy may still be low here while the UART registers the start.
                    state <= HOLD;
                end
                HOLD: begin
                    if (wait_cnt == '0) begin
                        if (last_q) begin
                            state <= CRC_LO;
                        end else begin
                            s_ready <= 1'b1;
                            state   <= GET;
                        end
                    end
                end
                CRC_LO: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= crc_l;
                        state    <= GUARD_L;
                    end
                end
                GUARD_L: begin
                    state <= CRC_HI;
                end
                CRC_HI: begin
                    if (!tx_busy) begin
                        tx_start   <= 1'b1;
                        tx_data    <= crc_h;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    s_ready <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modbus_frame_tx.sv
// Bench for modbus_frame_tx: CRC engine and UART models, randomized frames,
// and a frame-level CRC16 reference feeding a byte scoreboard.
module tb_modbus_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic       crc_init;
    logic       crc_load;
    logic [7:0] crc_byte;
    logic [7:0] crc_l;
    logic [7:0] crc_h;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       frame_done;
    logic [7:0] frame_len;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] len_q[$];
    logic [7:0] load_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    modbus_frame_tx #(.CRC_CYCLES(17), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .crc_init(crc_init), .crc_load(crc_load), .crc_byte(crc_byte),
        .crc_l(crc_l), .crc_h(crc_h),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .frame_done(frame_done), .frame_len(frame_len)
    );

    // ---------------- reference CRC ----------------
    function automatic logic [15:0] crc_byte_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    function automatic logic [15:0] ref_crc(input logic [7:0] f[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (f[i]) c = crc_byte_step(c, f[i]);
        return c;
    endfunction

    // ---------------- CRC engine model: result visible 17 cycles after load ----------------
    logic [15:0] eng_crc = 16'hFFFF;
    logic [15:0] eng_pend = 16'h0000;
    int          eng_cnt = 0;

    always @(posedge clk) begin
        if (crc_load) begin
            eng_pend <= crc_byte_step(eng_crc, crc_byte);
            eng_crc  <= eng_crc ^ 16'h5A5A;
            eng_cnt  <= 16;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) eng_crc <= eng_pend;
        end else if (crc_init) begin
            eng_crc <= 16'hFFFF;
        end
    end
    assign crc_l = eng_crc[7:0];
    assign crc_h = eng_crc[15:8];

    // ---------------- UART model: busy for busy_len cycles after each start ----------------
    int busy_len = 0;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (tx_start && busy_len != 0) busy_cnt <= busy_len;
        else if (busy_cnt != 0)         busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_crc_load", 32'(crc_load), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_crc_byte", 32'(crc_byte), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_frame_len", 32'(frame_len), 0);
        chk("rst_crc_init", 32'(crc_init), 1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int cyc = 0;
    int last_load = -1000;
    logic prev_busy = 1'b0;
    logic prev_start = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_busy  = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (tx_start) begin
                if (exp_q.size() == 0) chk("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
                else                   chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
                chk("tx_start_while_busy", 32'(prev_busy), 0);
                chk("tx_start_back_to_back", 32'(prev_start), 0);
            end
            if (frame_done) begin
                chk("done_with_start", 32'(tx_start), 1);
                if (len_q.size() == 0) chk("done_unexpected", 32'(frame_len), 32'hFFFF_FFFF);
                else                   chk("frame_len", 32'(frame_len), 32'(len_q.pop_front()));
            end
            if (crc_load) begin
                if (load_q.size() == 0) chk("load_unexpected", 32'(crc_byte), 32'hFFFF_FFFF);
                else                    chk("crc_byte", 32'(crc_byte), 32'(load_q.pop_front()));
                chk("load_spacing_ok", 32'((cyc - last_load) >= 17), 1);
                last_load = cyc;
            end
            if (s_ready) chk("ready_while_crc_busy", 32'(eng_cnt), 0);
            prev_busy  = tx_busy;
            prev_start = tx_start;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_byte(input logic [7:0] b, input logic last, input bit hold_valid);
        int  n;
        bit  got;
        s_valid = 1'b1;
        s_data  = b;
        s_last  = last;
        n   = 0;
        got = 0;
        while (!got && n < 3000) begin
            @(negedge clk);
            n++;
            if (s_ready) got = 1;
        end
        if (!got) begin
            chk("accept_timeout", 32'(n), 0);
        end else begin
            @(posedge clk);
            #1;
            load_q.push_back(b);
        end
        if (!hold_valid) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            s_last  = 1'($urandom);
        end
    endtask

    task automatic send_frame(input logic [7:0] f[$], input logic [15:0] crc_exp, input int gap_max);
        int g;
        foreach (f[i]) exp_q.push_back(f[i]);
        exp_q.push_back(crc_exp[7:0]);
        exp_q.push_back(crc_exp[15:8]);
        len_q.push_back((f.size() > 255) ? 8'd255 : 8'(f.size()));
        for (int i = 0; i < f.size(); i++) begin
            g = (gap_max == 0) ? 0 : $urandom_range(0, gap_max);
            drive_byte(f[i], (i == f.size() - 1), (g == 0) && (i != f.size() - 1));
            repeat (g) @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0 || len_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size() + len_q.size()), 0);
            exp_q.delete();
            len_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] fa[$];
    logic [7:0] fb[$];
    logic [7:0] fr[$];

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        fa = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        fb = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A};
        repeat (2) @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reference frame, UART always ready.
        send_frame(fa, 16'h0A84, 0);
        drain();

        // Two identical frames back to back: CRC re-initialised in between.
        send_frame(fb, 16'hCDC5, 0);
        send_frame(fb, 16'hCDC5, 0);
        drain();

        // Slow UART: busy for 20 cycles after every start.
        busy_len = 20;
        send_frame(fa, 16'h0A84, 0);
        drain();
        busy_len = 0;

        // Abort in HOLD of byte 3: first three bytes go out, no CRC, no frame_done.
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h00);
        drive_byte(8'h01, 1'b0, 1'b1);
        drive_byte(8'h03, 1'b0, 1'b1);
        drive_byte(8'h00, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        repeat (25) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(fa, 16'h0A84, 0);
        drain();

        // Single-byte frame.
        fr = '{8'hFF};
        send_frame(fr, ref_crc(fr), 0);
        drain();

        // Randomized frames, random gaps and UART busy lengths.
        for (int t = 0; t < 8; t++) begin
            int n;
            busy_len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 25);
            n = $urandom_range(1, 12);
            fr.delete();
            for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
            send_frame(fr, ref_crc(fr), $urandom_range(0, 3));
            drain();
        end
        busy_len = 0;

        // Long frame: frame_len saturates at 255.
        fr.delete();
        for (int i = 0; i < 260; i++) fr.push_back(8'($urandom));
        send_frame(fr, ref_crc(fr), 0);
        drain();

        chk("exp_q_empty", 32'(exp_q.size()), 0);
        chk("len_q_empty", 32'(len_q.size()), 0);
        chk("load_q_empty", 32'(load_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit for the whole run.
    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
